// File: rtl/uop_sequencer_pkg.sv
// uop_sequencer_pkg: shared constants and types for the micro-op sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: default micro-op width, FSM state encoding, slot index constants.
package uop_sequencer_pkg;

   localparam int UOP_W = 20;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_MULTI = 2'b01,
      S_LAST  = 2'b10
   } state_t;

   // Slot positions: slot 0 always holds the final micro-op of an instruction.
   localparam logic [1:0] IDX_UOP0 = 2'd0;
   localparam logic [1:0] IDX_UOP1 = 2'd1;
   localparam logic [1:0] IDX_UOP2 = 2'd2;

endpackage

// File: rtl/uop_sequencer_sat_counter.sv
// sat_counter: up-counter that sticks at all-ones; cleared only by reset.
// Latency: count visible the cycle after an inc edge.
// Backpressure: none; inc is sampled every rising edge.
// Ports: clk, a_rst (async active-low), inc (count enable), cnt (current count).
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         a_rst,
   input  logic         inc,
   output logic [W-1:0] cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         r_cnt <= '0;
      end else if (inc && (r_cnt != {W{1'b1}})) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;

endmodule

// File: rtl/uop_sequencer.sv
// uop_sequencer: buffers one decoded instruction (up to 3 micro-ops) and issues
//    them to execute one per cycle in order uop_2, uop_1, uop_0.
// Latency: feed_ack in cycle N -> first micro-op valid in cycle N+1; back-to-back
//    instructions issue with no bubble.
// Backpressure: hold freezes all state and outputs; flush empties the slot.
// Ports: clk, a_rst (async active-low); hold, flush; decode side feed_req/feed_ack,
//    uop_0..uop_2, uop_count; execute side exec_uop/exec_valid/exec_last; busy.
// Option: UOP_SEQ_PERF_EN adds perf_uops / perf_stalls saturating counters.
module uop_sequencer #(
   parameter int UOP_W = uop_sequencer_pkg::UOP_W,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             a_rst,
   input  logic             hold,
   input  logic             flush,
   output logic             feed_req,
   input  logic             feed_ack,
   input  logic [UOP_W-1:0] uop_0,
   input  logic [UOP_W-1:0] uop_1,
   input  logic [UOP_W-1:0] uop_2,
   input  logic [1:0]       uop_count,
   output logic [UOP_W-1:0] exec_uop,
   output logic             exec_valid,
   output logic             exec_last,
`ifdef UOP_SEQ_PERF_EN
   output logic [CNT_W-1:0] perf_uops,
   output logic [CNT_W-1:0] perf_stalls,
`endif
   output logic             busy
);

   import uop_sequencer_pkg::*;

   state_t           r_state, w_state_nxt;
   logic [1:0]       r_idx, w_idx_nxt;
   logic [UOP_W-1:0] r_slot0, r_slot1, r_slot2;
   logic             w_load;
   logic [1:0]       w_cnt;

   // Count 3 is illegal and collapses to 2 (three micro-ops).
   assign w_cnt = (uop_count == 2'd3) ? 2'd2 : uop_count;

   // Next-state: flush beats hold, hold beats everything else. A hold in S_IDLE
   // also freezes the sequencer, so an ack arriving then is not captured.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      w_load      = 1'b0;
      feed_req    = ((r_state == S_IDLE) || ((r_state == S_LAST) && !hold)) && !flush;
      if (flush) begin
         w_state_nxt = S_IDLE;
      end else if (!hold) begin
         case (r_state)
            S_IDLE:  w_load = feed_ack;
            S_MULTI: begin
               w_idx_nxt = r_idx - 2'd1;
               if (r_idx == 2'd1) w_state_nxt = S_LAST;
            end
            S_LAST: begin
               w_load = feed_ack;
               if (!feed_ack) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
         if (w_load) begin
            w_idx_nxt   = w_cnt;
            w_state_nxt = (w_cnt == 2'd0) ? S_LAST : S_MULTI;
         end
      end
   end

   always_ff @(posedge clk or negedge a_rst) begin
      if (!a_rst) begin
         r_state <= S_IDLE;
         r_idx   <= 2'd0;
         r_slot0 <= '0;
         r_slot1 <= '0;
         r_slot2 <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         if (w_load) begin
            r_slot0 <= uop_0;
            r_slot1 <= uop_1;
            r_slot2 <= uop_2;
         end
      end
   end

   // Output mux reads registers only, so no input-to-output combinational path.
   always_comb begin
      exec_uop = r_slot0;
      case (r_idx)
         IDX_UOP1: exec_uop = r_slot1;
         IDX_UOP2: exec_uop = r_slot2;
         default:  exec_uop = r_slot0;
      endcase
   end

   assign exec_valid = (r_state != S_IDLE);
   assign exec_last  = (r_state == S_LAST);
   assign busy       = (r_state != S_IDLE);

`ifdef UOP_SEQ_PERF_EN
   logic w_uop_inc, w_stall_inc;
   assign w_uop_inc   = exec_valid && !hold && !flush;
   assign w_stall_inc = exec_valid && hold;

   sat_counter #(.W(CNT_W)) u_perf_uops (
      .clk   (clk),
      .a_rst (a_rst),
      .inc   (w_uop_inc),
      .cnt   (perf_uops)
   );

   sat_counter #(.W(CNT_W)) u_perf_stalls (
      .clk   (clk),
      .a_rst (a_rst),
      .inc   (w_stall_inc),
      .cnt   (perf_stalls)
   );
`endif

endmodule

// File: tb/tb_uop_sequencer.sv
// tb_uop_sequencer: directed self-checking bench for uop_sequencer.
// Inputs change 1 time unit after each rising edge; outputs are checked 2 units after.
module tb_uop_sequencer;

   logic        clk = 1'b0;
   logic        a_rst = 1'b0;
   logic        hold = 1'b0;
   logic        flush = 1'b0;
   logic        feed_ack = 1'b0;
   logic [19:0] uop_0 = '0, uop_1 = '0, uop_2 = '0;
   logic [1:0]  uop_count = '0;
   logic        feed_req, exec_valid, exec_last, busy;
   logic [19:0] exec_uop;
`ifdef UOP_SEQ_PERF_EN
   logic [15:0] perf_uops, perf_stalls;
   logic        sc_inc = 1'b0;
   logic [2:0]  sc_cnt;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   uop_sequencer dut (
      .clk        (clk),
      .a_rst      (a_rst),
      .hold       (hold),
      .flush      (flush),
      .feed_req   (feed_req),
      .feed_ack   (feed_ack),
      .uop_0      (uop_0),
      .uop_1      (uop_1),
      .uop_2      (uop_2),
      .uop_count  (uop_count),
      .exec_uop   (exec_uop),
      .exec_valid (exec_valid),
      .exec_last  (exec_last),
`ifdef UOP_SEQ_PERF_EN
      .perf_uops  (perf_uops),
      .perf_stalls(perf_stalls),
`endif
      .busy       (busy)
   );

`ifdef UOP_SEQ_PERF_EN
   // Narrow instance so saturation is reached in a handful of cycles.
   sat_counter #(.W(3)) u_sc (.clk(clk), .a_rst(a_rst), .inc(sc_inc), .cnt(sc_cnt));
`endif

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ack_instr(input logic [1:0] cnt, input logic [19:0] u2, u1, u0);
      feed_ack = 1'b1; uop_count = cnt; uop_2 = u2; uop_1 = u1; uop_0 = u0;
   endtask

   task automatic test_reset();
      a_rst = 1'b0;
      #3;
      checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", exec_valid); end
      checks++; if (exec_last !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", exec_last); end
      checks++; if (exec_uop !== 20'h0) begin errors++; $display("FAIL rst_uop got %h want 00000", exec_uop); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
      checks++; if (feed_req !== 1'b1) begin errors++; $display("FAIL rst_feed_req got %b want 1", feed_req); end
      #20 a_rst = 1'b1;
      step();
   endtask

   task automatic test_single();
      ack_instr(2'd0, 20'h0, 20'h0, 20'h12345);
      #1;
      checks++; if (feed_req !== 1'b1) begin errors++; $display("FAIL single_req got %b want 1", feed_req); end
      step(); feed_ack = 1'b0; #1;
      checks++; if (exec_uop !== 20'h12345) begin errors++; $display("FAIL single_uop got %h want 12345", exec_uop); end
      checks++; if ({exec_valid, exec_last, busy} !== 3'b111) begin errors++; $display("FAIL single_flags got %b want 111", {exec_valid, exec_last, busy}); end
      step(); #1;
      checks++; if ({exec_valid, exec_last, busy} !== 3'b000) begin errors++; $display("FAIL single_idle got %b want 000", {exec_valid, exec_last, busy}); end
   endtask

   task automatic test_back_to_back();
      logic [19:0] exp_u [0:4];
      logic        exp_l [0:4];
      exp_u[0] = 20'hA0002; exp_u[1] = 20'hA0001; exp_u[2] = 20'hA0000; exp_u[3] = 20'hB0001; exp_u[4] = 20'hB0000;
      exp_l[0] = 1'b0;      exp_l[1] = 1'b0;      exp_l[2] = 1'b1;      exp_l[3] = 1'b0;      exp_l[4] = 1'b1;
      ack_instr(2'd2, 20'hA0002, 20'hA0001, 20'hA0000);
      for (int i = 0; i < 5; i++) begin
         step();
         feed_ack = 1'b0;
         // Second instruction (count 1) acked in the cycle that issues A0000.
         if (i == 2) ack_instr(2'd1, 20'hFFFFF, 20'hB0001, 20'hB0000);
         #1;
         checks++; if (exec_uop !== exp_u[i] || exec_valid !== 1'b1 || exec_last !== exp_l[i])
            begin errors++; $display("FAIL b2b_%0d got uop %h v %b l %b want %h 1 %b", i, exec_uop, exec_valid, exec_last, exp_u[i], exp_l[i]); end
         if (i == 2) begin
            checks++; if (feed_req !== 1'b1) begin errors++; $display("FAIL b2b_req got %b want 1", feed_req); end
         end
      end
      step(); #1;
      checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b want 0", exec_valid); end
   endtask

   task automatic test_hold();
      ack_instr(2'd2, 20'hA0002, 20'hA0001, 20'hA0000);
      step(); feed_ack = 1'b0;
      step(); hold = 1'b1; #1;
      checks++; if (exec_uop !== 20'hA0001) begin errors++; $display("FAIL hold_c0 got %h want A0001", exec_uop); end
      checks++; if (feed_req !== 1'b0) begin errors++; $display("FAIL hold_req got %b want 0", feed_req); end
      step(); #1;
      checks++; if (exec_uop !== 20'hA0001 || exec_valid !== 1'b1 || exec_last !== 1'b0)
         begin errors++; $display("FAIL hold_c1 got %h %b %b want A0001 1 0", exec_uop, exec_valid, exec_last); end
      step(); hold = 1'b0; #1;
      checks++; if (exec_uop !== 20'hA0001 || exec_valid !== 1'b1) begin errors++; $display("FAIL hold_c2 got %h %b want A0001 1", exec_uop, exec_valid); end
      step(); #1;
      checks++; if (exec_uop !== 20'hA0000 || exec_last !== 1'b1) begin errors++; $display("FAIL hold_after got %h %b want A0000 1", exec_uop, exec_last); end
      step(); #1;
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle got %b want 0", busy); end
   endtask

   task automatic test_flush();
      ack_instr(2'd2, 20'hA0002, 20'hA0001, 20'hA0000);
      step(); feed_ack = 1'b0;
      step();
      flush = 1'b1;
      ack_instr(2'd0, 20'h0, 20'h0, 20'hC0000);
      #1;
      checks++; if (exec_uop !== 20'hA0001) begin errors++; $display("FAIL flush_pre got %h want A0001", exec_uop); end
      checks++; if (feed_req !== 1'b0) begin errors++; $display("FAIL flush_req got %b want 0", feed_req); end
      step(); flush = 1'b0; feed_ack = 1'b0; #1;
      checks++; if (exec_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL flush_post got v %b b %b want 0 0", exec_valid, busy); end
      step(); #1;
      checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL flush_ack_ignored got %b want 0", exec_valid); end
   endtask

   task automatic test_async_reset();
      ack_instr(2'd2, 20'hA0002, 20'hA0001, 20'hA0000);
      step(); feed_ack = 1'b0;
      step(); #1;
      checks++; if (exec_uop !== 20'hA0001) begin errors++; $display("FAIL arst_pre got %h want A0001", exec_uop); end
      a_rst = 1'b0; #1;
      checks++; if (exec_valid !== 1'b0 || exec_uop !== 20'h0 || busy !== 1'b0)
         begin errors++; $display("FAIL arst_mid got v %b u %h b %b want 0 00000 0", exec_valid, exec_uop, busy); end
      #3 a_rst = 1'b1;
      step(); #1;
      checks++; if (exec_valid !== 1'b0) begin errors++; $display("FAIL arst_lost got %b want 0", exec_valid); end
   endtask

`ifdef UOP_SEQ_PERF_EN
   task automatic test_perf();
      a_rst = 1'b0; #2 a_rst = 1'b1;
      step();
      for (int i = 0; i < 4; i++) begin
         ack_instr(2'd1, 20'h0, 20'h11111, 20'h22222);
         step(); feed_ack = 1'b0;
         if (i < 3) begin
            hold = 1'b1;
            step(); hold = 1'b0;
         end
         step();
         step();
      end
      #1;
      checks++; if (perf_uops !== 16'd8) begin errors++; $display("FAIL perf_uops got %0d want 8", perf_uops); end
      checks++; if (perf_stalls !== 16'd3) begin errors++; $display("FAIL perf_stalls got %0d want 3", perf_stalls); end
      sc_inc = 1'b1;
      for (int i = 0; i < 9; i++) step();
      sc_inc = 1'b0;
      checks++; if (sc_cnt !== 3'h7) begin errors++; $display("FAIL perf_sat got %0d want 7", sc_cnt); end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_hold();
      test_flush();
      test_async_reset();
`ifdef UOP_SEQ_PERF_EN
      test_perf();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
